// File: rtl/nms_seq_if.sv
// nms_seq_if: frame-control, neighbour-read and result-write signals of nms_seq.
// Ports: start (frame request); refAddr/regAddr/rdEn drive the neighbour address
// calculator and srmData returns one cycle after rdEn; wrEn/wrAddr/wrData write
// the result SRAM; busy/done report frame progress.
interface nms_seq_if #(parameter int DW = 8);
  logic          start;
  logic [14:0]   refAddr;
  logic [3:0]    regAddr;
  logic          rdEn;
  logic [DW-1:0] srmData;
  logic          wrEn;
  logic [14:0]   wrAddr;
  logic [DW-1:0] wrData;
  logic          busy;
  logic          done;
  modport slave (input start, srmData, output refAddr, regAddr, rdEn, wrEn, wrAddr, wrData, busy, done);
  modport master (output start, srmData, input refAddr, regAddr, rdEn, wrEn, wrAddr, wrData, busy, done);
endinterface

// File: rtl/nms_seq.sv
// nms_seq: sequential 3x3 non-maximum suppression over one IMG_W x IMG_H frame.
// Ports: clk, rst (async, active-high); bus (nms_seq_if.slave) carries start,
// the neighbour read request (refAddr, regAddr, rdEn), returned srmData, the
// result write (wrEn, wrAddr, wrData) and busy/done status.
module nms_seq #(
  parameter int IMG_W = 180,
  parameter int IMG_H = 120,
  parameter int DW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  nms_seq_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, CHECK, READ, DRAIN, WRITE, DONE} state_t;
  localparam logic [14:0] W_LAST = 15'(IMG_W - 1);
  localparam logic [14:0] H_LAST = 15'(IMG_H - 1);
  state_t        state;
  logic [14:0]   row, col;
  logic [DW-1:0] c;
  logic          sup;
  logic          border, last;
  assign border = row == '0 || row == H_LAST || col == '0 || col == W_LAST;
  assign last   = row == H_LAST && col == W_LAST;
  // srmData lags regAddr by one cycle: during READ with regAddr=k it holds
  // the value for k-1, and DRAIN sees the value for neighbour 8.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      c           <= '0;
      sup         <= 1'b0;
      bus.refAddr <= '0;
      bus.regAddr <= '0;
      bus.rdEn    <= 1'b0;
      bus.wrEn    <= 1'b0;
      bus.wrAddr  <= '0;
      bus.wrData  <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.start) begin
          row         <= '0;
          col         <= '0;
          bus.refAddr <= '0;
          bus.busy    <= 1'b1;
          state       <= CHECK;
        end
        CHECK: begin
          sup <= 1'b0;
          if (border) begin
            bus.wrEn   <= 1'b1;
            bus.wrData <= '0;
            bus.wrAddr <= bus.refAddr;
            state      <= WRITE;
          end else begin
            bus.rdEn    <= 1'b1;
            bus.regAddr <= '0;
            state       <= READ;
          end
        end
        READ: begin
          if (bus.regAddr == 4'd1) c <= bus.srmData;
          else if (bus.regAddr != 4'd0 && bus.srmData > c) sup <= 1'b1;
          if (bus.regAddr == 4'd8) begin
            bus.rdEn    <= 1'b0;
            bus.regAddr <= '0;
            state       <= DRAIN;
          end else bus.regAddr <= bus.regAddr + 4'd1;
        end
        DRAIN: begin
          sup        <= sup || bus.srmData > c;
          bus.wrEn   <= 1'b1;
          bus.wrAddr <= bus.refAddr;
          bus.wrData <= (sup || bus.srmData > c) ? '0 : c;
          state      <= WRITE;
        end
        WRITE: begin
          bus.wrEn    <= 1'b0;
          bus.refAddr <= bus.refAddr + 15'd1;
          col         <= col == W_LAST ? '0 : col + 15'd1;
          row         <= col == W_LAST ? row + 15'd1 : row;
          if (last) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= DONE;
          end else state <= CHECK;
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_nms_seq.sv
// tb_nms_seq: randomized self-checking bench for nms_seq against a per-pixel NMS model.
module tb_nms_seq;
  localparam int W = 20;
  localparam int H = 12;
  localparam int N = W * H;
  logic clk = 1'b0;
  logic rst = 1'b1;
  nms_seq_if #(.DW(8)) bus();
  nms_seq #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] mem [N];
  int exp_data [N];
  int q [$];
  int rd_run = 0, last_rd = 0, prev_wr = 0, exp_done = -1, done_cnt = 0;
  int p, a, sa;
  bit done_seen = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int off(input int r);
    return r == 0 ? 0 : r <= 3 ? -W + r - 2 : r == 4 ? -1 : r == 5 ? 1 : W + r - 7;
  endfunction
  function automatic bit is_border(input int x);
    return x / W == 0 || x / W == H - 1 || x % W == 0 || x % W == W - 1;
  endfunction
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask
  // source SRAM behind the neighbour address calculator
  always @(posedge clk) begin
    sa = int'(bus.refAddr) + off(int'(bus.regAddr));
    if (bus.rdEn) bus.srmData <= (sa >= 0 && sa < N) ? mem[sa] : 8'h00;
  end
  always @(negedge clk)
    if (!rst) begin
      if (bus.rdEn) begin
        a = int'(bus.refAddr) + off(int'(bus.regAddr));
        chk("rd_regaddr", int'(bus.regAddr), rd_run);
        chk("rd_refaddr", int'(bus.refAddr), q.size() != 0 ? q[0] : -1);
        chk("rd_in_range", int'(a >= 0 && a < N), 1);
        rd_run++;
        last_rd = cyc;
      end else chk("idle_regaddr", int'(bus.regAddr), 0);
      if (bus.wrEn) begin
        if (q.size() == 0) chk("unexpected_wr", int'(bus.wrAddr), -1);
        else begin
          p = q.pop_front();
          chk("wr_addr", int'(bus.wrAddr), p);
          chk("wr_data", int'(bus.wrData), exp_data[p]);
          chk("wr_busy", int'(bus.busy), 1);
          if (is_border(p)) begin
            chk("border_reads", rd_run, 0);
            chk("border_gap", cyc - prev_wr, 2);
          end else begin
            chk("interior_reads", rd_run, 9);
            chk("rd_to_wr", cyc - last_rd, 2);
            chk("interior_gap", cyc - prev_wr, 12);
          end
          if (q.size() == 0) exp_done = cyc + 1;
        end
        rd_run = 0;
        prev_wr = cyc;
      end
      chk("done_pulse", int'(bus.done), int'(cyc == exp_done));
      if (bus.done) begin
        done_cnt++;
        done_seen = 1;
        chk("done_busy", int'(bus.busy), 0);
      end
    end
  task automatic build();
    for (int x = 0; x < N; x++) begin
      bit s = 0;
      if (!is_border(x))
        for (int r = 1; r <= 8; r++) if (mem[x + off(r)] > mem[x]) s = 1;
      exp_data[x] = (is_border(x) || s) ? 0 : int'(mem[x]);
    end
    q.delete();
    for (int x = 0; x < N; x++) q.push_back(x);
    done_cnt = 0;
    done_seen = 0;
    exp_done = -1;
    rd_run = 0;
  endtask
  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    prev_wr = cyc - 1;
  endtask
  task automatic run_frame(input bit noisy);
    build();
    pulse_start();
    for (int i = 0; i < N * 13 + 20; i++) begin
      @(posedge clk); #1;
      if (done_seen) break;
      bus.start = noisy && bus.busy && (i % 37 == 5);
    end
    bus.start = 1'b0;
    chk("frame_done_seen", int'(done_seen), 1);
    chk("writes_left", q.size(), 0);
    repeat (3) @(posedge clk);
    #1 chk("one_done", done_cnt, 1);
  endtask
  task automatic outputs_zero(input string tag);
    chk({tag, "_refAddr"}, int'(bus.refAddr), 0);
    chk({tag, "_regAddr"}, int'(bus.regAddr), 0);
    chk({tag, "_rdEn"}, int'(bus.rdEn), 0);
    chk({tag, "_wrEn"}, int'(bus.wrEn), 0);
    chk({tag, "_wrAddr"}, int'(bus.wrAddr), 0);
    chk({tag, "_wrData"}, int'(bus.wrData), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
  endtask
  initial begin
    bit hit;
    bus.start = 1'b0;
    #12 outputs_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    foreach (mem[x]) mem[x] = 8'd0;
    run_frame(0);
    foreach (mem[x]) mem[x] = 8'd10;
    mem[5 * W + 7] = 8'd200;
    build();
    chk("pin_peak", exp_data[5 * W + 7], 200);
    chk("pin_peak_nb", exp_data[4 * W + 8], 0);
    chk("pin_flat", exp_data[2 * W + 2], 10);
    chk("pin_border", exp_data[W - 1], 0);
    run_frame(0);
    foreach (mem[x]) mem[x] = 8'd0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) mem[(5 + dr) * W + 7 + dc] = 8'd50;
    build();
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) chk("pin_plateau", exp_data[(5 + dr) * W + 7 + dc], 50);
    chk("pin_plateau_edge", exp_data[3 * W + 7], 0);
    run_frame(0);
    foreach (mem[x]) mem[x] = 8'($urandom_range(0, 255));
    run_frame(0);
    foreach (mem[x]) mem[x] = 8'($urandom_range(0, 3));
    run_frame(1);
    foreach (mem[x]) mem[x] = 8'($urandom_range(0, 255));
    build();
    pulse_start();
    hit = 0;
    for (int i = 0; i < N * 13; i++) begin
      @(negedge clk);
      if (bus.rdEn && bus.refAddr == 15'(5 * W + 7) && bus.regAddr == 4'd3) begin
        hit = 1;
        break;
      end
    end
    chk("abort_reached", int'(hit), 1);
    #2 rst = 1'b1;
    #1 outputs_zero("abort");
    q.delete();
    exp_done = -1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("abort_no_done", done_cnt, 0);
    foreach (mem[x]) mem[x] = 8'($urandom_range(0, 255));
    run_frame(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nms_seq.md
NMS_SEQ -- requirements
Module: nms_seq

Interface
REQ-001 The block SHALL have parameter IMG_W, default 180, meaning image width in pixels; it SHALL equal the row stride hardwired in the 3x3 neighbour address calculator.
REQ-002 The block SHALL have parameter IMG_H, default 120, meaning image height in pixels; IMG_W*IMG_H SHALL be at most 32768.
REQ-003 The block SHALL have parameter DW, default 8, meaning magnitude data width.
REQ-004 clk  input  1  the single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  one-cycle request to process one full frame.
REQ-007 refAddr  output  15  centre pixel address, row*IMG_W+col, to the neighbour address calculator.
REQ-008 regAddr  output  4  neighbour select to the address calculator: 0 centre, 1..8 = -W-1, -W, -W+1, -1, +1, +W-1, +W, +W+1.
REQ-009 rdEn  output  1  source SRAM read strobe for the calculator-produced address.
REQ-010 srmData  input  DW  source SRAM read data, valid exactly one cycle after rdEn.
REQ-011 wrEn  output  1  result SRAM write strobe.
REQ-012 wrAddr  output  15  result address, equal to refAddr of the pixel written.
REQ-013 wrData  output  DW  NMS result value.
REQ-014 busy  output  1  high from the cycle after an accepted start until done.
REQ-015 done  output  1  one-cycle pulse after the final write of a frame.

Function
REQ-016 States SHALL be IDLE, CHECK, READ, DRAIN, WRITE, DONE.
REQ-017 In IDLE, start=1 SHALL clear the row and column counters to 0, set refAddr=0 and enter CHECK; start SHALL be ignored in every other state.
REQ-018 In CHECK, a border pixel (row 0, row IMG_H-1, col 0, col IMG_W-1) SHALL go directly to WRITE with wrData=0 and no reads; an interior pixel SHALL enter READ with regAddr=0.
REQ-019 READ SHALL last 9 cycles: rdEn=1 with regAddr stepping 0,1,...,8, one value per cycle; after regAddr=8 the state SHALL become DRAIN.
REQ-020 DRAIN SHALL last 1 cycle with rdEn=0 to capture the srmData for regAddr=8, then the state SHALL enter WRITE.
REQ-021 The srmData captured for regAddr=0 SHALL be latched as the centre value C; each later neighbour N SHALL set a suppress flag if N>C (unsigned, strict).
REQ-022 Equality SHALL NOT suppress; ties keep the centre.
REQ-023 WRITE SHALL assert wrEn for exactly 1 cycle, with wrData = suppress ? 0 : C and wrAddr = refAddr.
REQ-024 After WRITE, col SHALL increment; at col=IMG_W-1, col SHALL wrap to 0 and row SHALL increment.
REQ-025 refAddr SHALL increment by 1 per pixel, with no multiplier.
REQ-026 If the written pixel was the last one (row IMG_H-1, col IMG_W-1), the state SHALL enter DONE; otherwise it SHALL enter CHECK.
REQ-027 DONE SHALL assert done=1 for 1 cycle with busy=0, then return to IDLE.
REQ-028 Interior pixel latency SHALL be 12 cycles (CHECK 1 + READ 9 + DRAIN 1 + WRITE 1); border pixel latency SHALL be 2 cycles.
REQ-029 regAddr SHALL be 0 whenever rdEn=0; the suppress flag SHALL clear in CHECK.
REQ-030 Frame size SHALL be 2*(IMG_W+IMG_H)-4 border pixels and (IMG_W-2)*(IMG_H-2) interior pixels; no address outside 0..IMG_W*IMG_H-1 SHALL ever be read.

Reset
REQ-031 While rst=1, state SHALL be IDLE and every output SHALL be 0 (refAddr, regAddr, rdEn, wrEn, wrAddr, wrData, busy, done), with counters, C and the suppress flag cleared.
REQ-032 Reset asserted mid-frame SHALL abort immediately with no further wrEn pulses; a new start after release SHALL restart at pixel 0.

Verification
REQ-033 Frame of all zeros, start pulse -> 21600 wrEn pulses, all wrData=0, addresses 0..21599 in order, a single done pulse.
REQ-034 Single peak 200 at (row 5, col 7), all else 10 -> wrData 200 at address 907; interior neighbours of the peak write 0; other interior pixels write 10; border pixels write 0.
REQ-035 Plateau: 3x3 block of 50 centred at address 907, surround 0 -> all 9 block pixels write 50 (ties keep).
REQ-036 Interior pixel timing: rdEn high for 9 consecutive cycles, regAddr 0..8, wrEn 2 cycles after the last rdEn; border pixel: wrEn 1 cycle after CHECK, no rdEn.
REQ-037 start pulses during busy -> ignored, no restart, exactly one done per frame.
REQ-038 rst pulse during READ of pixel 400 -> all outputs 0 within the same cycle, no write to address 400, then a clean full frame after the next start.
